down_counter4: RTL and testbench



---
 rtl/down_counter4_if.sv | 52 +++++
 rtl/down_counter4.sv | 66 ++++++
 tb/tb_down_counter4.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/down_counter4_if.sv
// ---------------------------------------------------------------------------
// down_counter4_if
//
// Purpose: bundles the control and status signals of the loadable down
// counter so the counter and whatever drives it share one connection.
// Clock and clear are deliberately kept out of the bundle; they stay plain
// ports on the counter.
//
// Signals:
//   LOAD   - parallel load request (master -> slave)
//   EN     - count enable (master -> slave)
//   AUTO   - terminal-count mode: 1 reload saved start, 0 wrap to all-ones
//   D      - parallel load value, WIDTH bits (master -> slave)
//   NUM    - current count, WIDTH bits (slave -> master)
//   ZERO   - high while NUM is zero (slave -> master)
//   BORROW - one-period pulse after a terminal-count step (slave -> master)
//
// Modports:
//   master - the controller side (drives LOAD/EN/AUTO/D)
//   slave  - the counter side (drives NUM/ZERO/BORROW)
// ---------------------------------------------------------------------------
interface down_counter4_if #(
    parameter int WIDTH = 4
);
    logic             LOAD;
    logic             EN;
    logic             AUTO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] NUM;
    logic             ZERO;
    logic             BORROW;

    modport master (
        output LOAD,
        output EN,
        output AUTO,
        output D,
        input  NUM,
        input  ZERO,
        input  BORROW
    );

    modport slave (
        input  LOAD,
        input  EN,
        input  AUTO,
        input  D,
        output NUM,
        output ZERO,
        output BORROW
    );
endinterface

// File: rtl/down_counter4.sv
// ---------------------------------------------------------------------------
// down_counter4
//
// Purpose: synchronous, loadable down counter with asynchronous clear. It
// loads a start value, decrements on enabled falling clock edges and marks
// terminal count with a level (ZERO) and a one-period pulse (BORROW). In
// auto-reload mode it restarts from the last loaded value, so it works as a
// programmable divider/timer: a start value of N gives one BORROW every N+1
// enabled edges, and a start value of 0 gives a BORROW on every enabled edge.
// All flip-flops share one clock, so there is no ripple between bits.
//
// Ports:
//   CLK       - clock; every state change happens on its falling edge
//   CLEAR_BAR - asynchronous active-low clear (count, reload value, borrow)
//   bus       - down_counter4_if slave modport: LOAD, EN, AUTO, D in;
//               NUM, ZERO, BORROW out
// ---------------------------------------------------------------------------
module down_counter4 #(
    parameter int WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 CLEAR_BAR,
    down_counter4_if.slave       bus
);

    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_reload;
    logic             r_borrow;
    logic             w_atZero;

    // Terminal count is just "the count is zero"; it carries no state of its
    // own and feeds both the ZERO output and the wrap/reload decision.
    assign w_atZero = (r_num == '0);

    // Counter state. Clear wins over everything and acts without a clock
    // edge. Otherwise the first matching case applies: a load (which also
    // captures the reload value and beats a simultaneous enable), a plain
    // decrement, or the terminal-count step that either reloads the saved
    // start value or wraps to all-ones and raises BORROW for one period.
    // Any edge that is not a terminal-count step drops BORROW again.
    always_ff @(negedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) begin
            r_num    <= '0;
            r_reload <= '0;
            r_borrow <= 1'b0;
        end else if (bus.LOAD) begin
            r_num    <= bus.D;
            r_reload <= bus.D;
            r_borrow <= 1'b0;
        end else if (bus.EN && !w_atZero) begin
            r_num    <= r_num - WIDTH'(1);
            r_borrow <= 1'b0;
        end else if (bus.EN) begin
            r_num    <= bus.AUTO ? r_reload : '1;
            r_borrow <= 1'b1;
        end else begin
            r_borrow <= 1'b0;
        end
    end

    // Status outputs onto the interface.
    assign bus.NUM    = r_num;
    assign bus.ZERO   = w_atZero;
    assign bus.BORROW = r_borrow;

endmodule

// File: tb/tb_down_counter4.sv
// ---------------------------------------------------------------------------
// tb_down_counter4
//
// Purpose: directed, self-checking bench for down_counter4. Inputs change
// just after the rising clock edge and outputs are observed there too, half
// a period away from the falling edge where the counter moves. Every
// expected value below is worked out by hand from the counter's behaviour.
// ---------------------------------------------------------------------------
module tb_down_counter4;

    logic clk;
    logic clearBar;
    int   totalChecks;
    int   badChecks;

    down_counter4_if #(.WIDTH(4)) bus ();

    down_counter4 #(.WIDTH(4)) dut (
        .CLK       (clk),
        .CLEAR_BAR (clearBar),
        .bus       (bus)
    );

    // Clock starts low: rising edges at 5, 15, 25...; falling at 10, 20...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it and report it when it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the control inputs for the next falling edge.
    task automatic applyStimulus(input logic load, input logic en, input logic autoMode,
                                 input logic [3:0] d);
        bus.LOAD = load;
        bus.EN   = en;
        bus.AUTO = autoMode;
        bus.D    = d;
    endtask

    // Advance to just after the next rising edge (one falling edge has passed).
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Check NUM, ZERO and BORROW together.
    task automatic checkAll(input string tag, input int num, input int zero, input int borrow);
        checkOutput({tag, ".num"}, int'(bus.NUM), num);
        checkOutput({tag, ".zero"}, int'(bus.ZERO), zero);
        checkOutput({tag, ".borrow"}, int'(bus.BORROW), borrow);
    endtask

    initial begin
        int downSeq[7]  = '{4, 3, 2, 1, 0, 15, 14};
        int downBor[7]  = '{0, 0, 0, 0, 0, 1, 0};
        int autoSeq[12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
        int autoBor[12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        int pulses;

        totalChecks = 0;
        badChecks   = 0;

        // Reset then idle.
        clearBar = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        checkAll("reset_held", 0, 1, 0);
        #4 clearBar = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkAll($sformatf("idle%0d", i), 0, 1, 0);
        end

        // Load 5 and count down with wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
        nextCycle();
        checkAll("load5", 5, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            nextCycle();
            checkAll($sformatf("down%0d", i), downSeq[i], (downSeq[i] == 0) ? 1 : 0, downBor[i]);
        end

        // Auto-reload divider from 3.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3);
        nextCycle();
        checkAll("load3", 3, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            checkAll($sformatf("auto%0d", i), autoSeq[i], (autoSeq[i] == 0) ? 1 : 0, autoBor[i]);
            if (bus.BORROW) pulses++;
        end
        checkOutput("auto_pulse_count", pulses, 3);

        // Enable gating, then LOAD beating EN on the same edge.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
        nextCycle();
        checkAll("load9", 9, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkAll($sformatf("hold%0d", i), 9, 0, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd12);
        nextCycle();
        checkAll("load_over_en", 12, 0, 0);

        // Async clear in the low phase while auto-reloading from 7.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd7);
        nextCycle();
        checkAll("load7", 7, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        nextCycle();
        checkAll("run6", 6, 0, 0);
        nextCycle();
        checkAll("run5", 5, 0, 0);
        @(negedge clk);
        #2;
        checkAll("run4_low_phase", 4, 0, 0);
        clearBar = 1'b0;
        #1;
        checkAll("clear_now", 0, 1, 0);
        nextCycle();
        checkAll("clear_held", 0, 1, 0);
        clearBar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkAll($sformatf("after_clear%0d", i), 0, 1, 1);
        end

        // Zero reload value: divide-by-1.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        nextCycle();
        checkAll("load0", 0, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkAll($sformatf("zero_reload%0d", i), 0, 1, 1);
        end

        // LOAD at terminal count: load happens and no borrow.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd6);
        nextCycle();
        checkAll("load_at_zero", 6, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        nextCycle();
        checkAll("after_load_at_zero", 5, 0, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
